// File: rtl/gpio_if.sv
// Bus-side signal bundle for the GPIO block: a 32-bit, zero-wait-state
// register bus with per-byte write enables.
interface gpio_if;
  logic [31:0] address_in;
  logic        sel_in;
  logic        read_in;
  logic [31:0] read_value_out;
  logic [3:0]  write_mask_in;
  logic [31:0] write_value_in;
  logic        ready_out;

  modport master (
    output address_in, sel_in, read_in, write_mask_in, write_value_in,
    input  read_value_out, ready_out
  );

  modport slave (
    input  address_in, sel_in, read_in, write_mask_in, write_value_in,
    output read_value_out, ready_out
  );
endinterface

// File: rtl/gpio.sv
// General-purpose I/O block: output/direction registers, synchronised pad
// inputs, per-bit rise/fall edge capture into a write-1-to-clear status register.
module gpio #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  gpio_if.slave            bus,
  input  logic [WIDTH-1:0] pins_in,
  output logic [WIDTH-1:0] pins_out,
  output logic [WIDTH-1:0] pins_oe,
  output logic             irq_out
);

  typedef enum logic [2:0] {
    REG_OUT     = 3'd0,
    REG_IN      = 3'd1,
    REG_DIR     = 3'd2,
    REG_RISE_EN = 3'd3,
    REG_FALL_EN = 3'd4,
    REG_STATUS  = 3'd5,
    REG_OUT_SET = 3'd6,
    REG_OUT_CLR = 3'd7
  } reg_e;

  // Edge detection stays off until the synchroniser and delay flop hold real pad data.
  localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 1);

  reg_e             reg_sel;
  logic [WIDTH-1:0] lane_en;
  logic [WIDTH-1:0] wbits;
  logic [WIDTH-1:0] out_q, dir_q, rise_en_q, fall_en_q, status_q;
  logic [WIDTH-1:0] out_d, dir_d, rise_en_d, fall_en_d, status_d;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] in_val;
  logic [WIDTH-1:0] edge_evt;
  logic [2:0]       warm_q;
  logic [31:0]      rdata;
  logic             unused_ok;

  assign reg_sel = reg_e'(bus.address_in[4:2]);

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      lane_en[i] = bus.write_mask_in[i / 8];
    end
  end

  assign wbits    = bus.write_value_in[WIDTH-1:0] & lane_en;
  assign in_val   = sync_q[SYNC_STAGES-1];
  assign edge_evt = (warm_q == WARM_DONE)
                  ? ((in_val & ~prev_q & rise_en_q) | (~in_val & prev_q & fall_en_q))
                  : '0;

  // NOTE: every output of this block gets its default first, so no path leaves one unassigned (no latch).
  always_comb begin
    out_d     = out_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    status_d  = status_q;
    if (bus.sel_in) begin
      case (reg_sel)
        REG_OUT:     out_d     = (out_q & ~lane_en) | wbits;
        REG_IN:      ;
        REG_DIR:     dir_d     = (dir_q & ~lane_en) | wbits;
        REG_RISE_EN: rise_en_d = (rise_en_q & ~lane_en) | wbits;
        REG_FALL_EN: fall_en_d = (fall_en_q & ~lane_en) | wbits;
        REG_STATUS:  status_d  = status_q & ~wbits;
        REG_OUT_SET: out_d     = out_q | wbits;
        REG_OUT_CLR: out_d     = out_q & ~wbits;
      endcase
    end
    // An edge landing in the same cycle as a clear wins, so no event is lost.
    status_d = status_d | edge_evt;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      prev_q    <= '0;
      warm_q    <= '0;
      // NOTE: the synchroniser array is a handful of flops, not a RAM, so it is reset like any register.
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      prev_q    <= in_val;
      sync_q[0] <= pins_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      if (warm_q != WARM_DONE) begin
        warm_q <= warm_q + 3'd1;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (bus.sel_in) begin
      case (reg_sel)
        REG_OUT:     rdata[WIDTH-1:0] = out_q;
        REG_IN:      rdata[WIDTH-1:0] = in_val;
        REG_DIR:     rdata[WIDTH-1:0] = dir_q;
        REG_RISE_EN: rdata[WIDTH-1:0] = rise_en_q;
        REG_FALL_EN: rdata[WIDTH-1:0] = fall_en_q;
        REG_STATUS:  rdata[WIDTH-1:0] = status_q;
        REG_OUT_SET: rdata = '0;
        REG_OUT_CLR: rdata = '0;
      endcase
    end
  end

  assign bus.read_value_out = rdata;
  assign bus.ready_out      = bus.sel_in;
  assign pins_out           = out_q;
  assign pins_oe            = dir_q;
  assign irq_out            = |status_q;

  // Address bits outside [4:2], the read strobe and lanes above WIDTH carry no function.
  assign unused_ok = ^{bus.address_in[31:5], bus.address_in[1:0], bus.read_in,
                       bus.write_value_in, bus.write_mask_in};

endmodule

// File: tb/tb_gpio.sv
// Self-checking bench: an 8-bit/2-stage and a 32-bit/3-stage GPIO share one
// bus stimulus and are compared every cycle against a register-level model.
module tb_gpio;
  localparam int S0 = 2;
  localparam int S1 = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic [31:0] pins = '0;

  logic [7:0]  p_out0, p_oe0;
  logic [31:0] p_out1, p_oe1;
  logic        irq0, irq1;

  int checks = 0;
  int errors = 0;

  gpio_if bus0 ();
  gpio_if bus1 ();

  gpio #(.WIDTH(8), .SYNC_STAGES(S0)) u0 (
    .clk(clk), .reset(reset), .bus(bus0.slave), .pins_in(pins[7:0]),
    .pins_out(p_out0), .pins_oe(p_oe0), .irq_out(irq0)
  );

  gpio #(.WIDTH(32), .SYNC_STAGES(S1)) u1 (
    .clk(clk), .reset(reset), .bus(bus1.slave), .pins_in(pins),
    .pins_out(p_out1), .pins_oe(p_oe1), .irq_out(irq1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input logic [31:0] a, input logic [3:0] m,
                       input logic [31:0] v, input logic r);
    bus0.sel_in = s; bus0.address_in = a; bus0.write_mask_in = m;
    bus0.write_value_in = v; bus0.read_in = r;
    bus1.sel_in = s; bus1.address_in = a; bus1.write_mask_in = m;
    bus1.write_value_in = v; bus1.read_in = r;
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_out [2], m_dir [2], m_rise [2], m_fall [2], m_stat [2];
  logic [31:0] m_s1 [2], m_s2 [2];
  logic [31:0] samples [$];
  int          n_edges;

  function automatic logic [31:0] wmask(input int i);
    return (i == 0) ? 32'h0000_00FF : 32'hFFFF_FFFF;
  endfunction

  function automatic int stages(input int i);
    return (i == 0) ? S0 : S1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_out[i] = '0; m_dir[i] = '0; m_rise[i] = '0; m_fall[i] = '0;
      m_stat[i] = '0; m_s1[i] = '0; m_s2[i] = '0;
    end
    samples.delete();
    n_edges = 0;
  endtask

  task automatic model_edge();
    logic [31:0] bm, be, wv, ev;
    for (int b = 0; b < 4; b++) bm[8*b +: 8] = {8{bus0.write_mask_in[b]}};
    n_edges++;
    samples.push_back(pins);
    for (int i = 0; i < 2; i++) begin
      be = bm & wmask(i);
      wv = bus0.write_value_in & be;
      ev = '0;
      if (n_edges >= stages(i) + 2)
        ev = (m_s1[i] & ~m_s2[i] & m_rise[i]) | (~m_s1[i] & m_s2[i] & m_fall[i]);
      if (bus0.sel_in) begin
        case (bus0.address_in[4:2])
          3'd0: m_out[i]  = (m_out[i]  & ~be) | wv;
          3'd2: m_dir[i]  = (m_dir[i]  & ~be) | wv;
          3'd3: m_rise[i] = (m_rise[i] & ~be) | wv;
          3'd4: m_fall[i] = (m_fall[i] & ~be) | wv;
          3'd5: m_stat[i] = m_stat[i] & ~wv;
          3'd6: m_out[i]  = m_out[i] | wv;
          3'd7: m_out[i]  = m_out[i] & ~wv;
          default: ;
        endcase
      end
      m_stat[i] = m_stat[i] | ev;
      m_s2[i] = m_s1[i];
      m_s1[i] = (samples.size() >= stages(i))
              ? (samples[samples.size() - stages(i)] & wmask(i)) : '0;
    end
    if (samples.size() > 8) void'(samples.pop_front());
  endtask

  function automatic logic [31:0] exp_rd(input int i);
    if (!bus0.sel_in) return '0;
    case (bus0.address_in[4:2])
      3'd0: return m_out[i];
      3'd1: return m_s1[i];
      3'd2: return m_dir[i];
      3'd3: return m_rise[i];
      3'd4: return m_fall[i];
      3'd5: return m_stat[i];
      default: return '0;
    endcase
  endfunction

  always @(negedge reset) model_reset();

  // Single compare process: model advances on the edge, DUT sampled 1ns later.
  always begin
    @(posedge clk);
    if (reset) model_edge();
    #1;
    check("u0_pins_out", {24'b0, p_out0}, m_out[0]);
    check("u0_pins_oe",  {24'b0, p_oe0},  m_dir[0]);
    check("u0_irq",      {31'b0, irq0},   {31'b0, |m_stat[0]});
    check("u0_rdata",    bus0.read_value_out, exp_rd(0));
    check("u0_ready",    {31'b0, bus0.ready_out}, {31'b0, bus0.sel_in});
    check("u1_pins_out", p_out1, m_out[1]);
    check("u1_pins_oe",  p_oe1,  m_dir[1]);
    check("u1_irq",      {31'b0, irq1},   {31'b0, |m_stat[1]});
    check("u1_rdata",    bus1.read_value_out, exp_rd(1));
    check("u1_ready",    {31'b0, bus1.ready_out}, {31'b0, bus1.sel_in});
  end

  // ---------------- directed helpers ----------------
  task automatic bus_write(input logic [31:0] a, input logic [3:0] m, input logic [31:0] v);
    @(negedge clk);
    drive(1'b1, a, m, v, 1'b0);
    @(negedge clk);
    drive(1'b0, '0, 4'h0, '0, 1'b0);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] v0, output logic [31:0] v1);
    @(negedge clk);
    drive(1'b1, a, 4'h0, 32'hFFFF_FFFF, 1'b1);
    #1;
    v0 = bus0.read_value_out;
    v1 = bus1.read_value_out;
    @(negedge clk);
    drive(1'b0, '0, 4'h0, '0, 1'b0);
  endtask

  localparam logic [31:0] A_OUT = 32'h00, A_IN = 32'h04, A_DIR = 32'h08, A_RISE = 32'h0C;
  localparam logic [31:0] A_STAT = 32'h14, A_SET = 32'h18, A_CLR = 32'h1C;

  initial begin
    logic [31:0] v0, v1;
    model_reset();
    drive(1'b0, '0, 4'h0, '0, 1'b0);

    // Reset held, then released between edges.
    repeat (2) @(negedge clk);
    check("rst_pins_out", {24'b0, p_out0}, 32'h0);
    #2 reset = 1'b1;
    #1;
    check("rel_pins_oe", p_oe1, 32'h0);
    check("rel_irq", {31'b0, irq0 | irq1}, 32'h0);

    // DIR then OUT on the low byte.
    bus_write(A_DIR, 4'b0001, 32'h0000_00FF);
    bus_write(A_OUT, 4'b0001, 32'h0000_00A5);
    check("dir_pins_oe", {24'b0, p_oe0}, 32'h0000_00FF);
    check("out_pins_out", {24'b0, p_out0}, 32'h0000_00A5);
    bus_read(A_OUT, v0, v1);
    check("read_out", v0, 32'h0000_00A5);

    // Set/clear aliases.
    bus_write(A_OUT, 4'hF, 32'h0000_000F);
    bus_write(A_SET, 4'hF, 32'h0000_0030);
    bus_write(A_CLR, 4'hF, 32'h0000_0003);
    check("setclr_out", {24'b0, p_out0}, 32'h0000_003C);
    bus_read(A_SET, v0, v1);
    check("read_out_set", v0, 32'h0);

    // Enabled rise on bit 3 reaches STATUS exactly S0+1 edges after the pad change.
    bus_write(A_RISE, 4'hF, 32'h0000_0008);
    pins = 32'h0000_0008;
    repeat (S0) @(negedge clk);
    check("rise_early_irq", {31'b0, irq0}, 32'h0);
    @(negedge clk);
    check("rise_irq", {31'b0, irq0}, 32'h1);
    bus_read(A_STAT, v0, v1);
    check("rise_status", v0, 32'h0000_0008);
    bus_read(A_IN, v0, v1);
    check("read_in", v0, 32'h0000_0008);
    pins = 32'h0;
    repeat (S0 + 3) @(negedge clk);
    bus_read(A_STAT, v0, v1);
    check("fall_ignored", v0, 32'h0000_0008);

    // Clear collides with a fresh enabled rise: status must survive.
    pins = 32'h0000_0008;
    repeat (S0) @(negedge clk);
    drive(1'b1, A_STAT, 4'b0001, 32'h0000_0008, 1'b0);
    @(negedge clk);
    drive(1'b0, '0, 4'h0, '0, 1'b0);
    check("collide_irq", {31'b0, irq0}, 32'h1);
    bus_read(A_STAT, v0, v1);
    check("collide_status", v0, 32'h0000_0008);
    bus_write(A_STAT, 4'b0001, 32'h0000_0008);
    check("w1c_irq", {31'b0, irq0 | irq1}, 32'h0);

    // Single-lane write on the 32-bit instance; deselected write ignored.
    bus_write(A_OUT, 4'hF, 32'h0);
    bus_write(A_OUT, 4'b0100, 32'h1234_5678);
    bus_read(A_OUT, v0, v1);
    check("lane_out_w32", v1, 32'h0034_0000);
    check("lane_out_w8", v0, 32'h0);
    @(negedge clk);
    drive(1'b0, A_OUT, 4'hF, 32'hFFFF_FFFF, 1'b0);
    #1;
    check("nosel_rdata", bus1.read_value_out, 32'h0);
    @(negedge clk);
    drive(1'b0, '0, 4'h0, '0, 1'b0);
    bus_read(A_OUT, v0, v1);
    check("nosel_out", v1, 32'h0034_0000);

    // Reset mid-operation with pads high and all rises enabled.
    bus_write(A_RISE, 4'hF, 32'hFFFF_FFFF);
    bus_write(A_DIR, 4'hF, 32'hFFFF_FFFF);
    pins = 32'h0000_00FF;
    repeat (6) @(negedge clk);
    check("pre_rst_irq", {31'b0, irq1}, 32'h1);
    @(negedge clk);
    drive(1'b1, A_OUT, 4'hF, 32'hDEAD_BEEF, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("async_rst_oe", p_oe1, 32'h0);
    check("async_rst_irq", {31'b0, irq0 | irq1}, 32'h0);
    @(negedge clk);
    drive(1'b0, '0, 4'h0, '0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("rel2_pins_out", p_out1, 32'h0);
    repeat (S1 + 4) @(negedge clk);
    check("no_spurious_irq", {31'b0, irq0 | irq1}, 32'h0);
    bus_read(A_STAT, v0, v1);
    check("no_spurious_status", v1, 32'h0);
    bus_read(A_RISE, v0, v1);
    check("rst_rise_en", v1, 32'h0);
    bus_read(A_OUT, v0, v1);
    check("rst_out_discarded", v1, 32'h0);

    // Randomised traffic, with occasional asynchronous reset pulses.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c % 731 == 730) begin
        drive(1'b1, $urandom, 4'hF, $urandom, 1'b0);
        #2 reset = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
      end else begin
        drive($urandom_range(0, 4) != 0, $urandom, 4'($urandom_range(0, 15)),
              $urandom, 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 3) == 0) pins = pins ^ ($urandom & $urandom & $urandom);
      end
    end
    @(negedge clk);
    drive(1'b0, '0, 4'h0, '0, 1'b0);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
